// File: rtl/decode_core.sv
// decode_core: RV32I decode stage core, combining the control unit, the immediate generator and a 32x32 register file.
// Ports: clk, reset (async, active-high), i_instruction, i_wb_addr/i_wb_data/i_wb_en (writeback write port), i_dump,
//        o_rs1_val/o_rs2_val (register reads with write-through), o_sext_imm, o_instr_type, o_alu_op, control flags.
// Optional feature: define DECODE_DUMP_EN to print every register on each clock edge where i_dump=1.
module decode_core #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         i_instruction,
  input  logic [4:0]          i_wb_addr,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_wb_en,
  input  logic                i_dump,
  output logic [XLEN-1:0]     o_rs1_val,
  output logic [XLEN-1:0]     o_rs2_val,
  output logic [XLEN-1:0]     o_sext_imm,
  output logic [2:0]          o_instr_type,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_reg_write,
  output logic                o_use_imm,
  output logic                o_is_branch,
  output logic                o_is_jump,
  output logic                o_is_jalr,
  output logic                o_is_final
);
  localparam logic [ALU_OP_W-1:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5,
                                  SRL = 6, SRA = 7, OR = 8, AND = 9, PASSB = 10;
  localparam logic [2:0] T_R = 0, T_I = 1, T_S = 2, T_B = 3, T_U = 4, T_J = 5;
  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic [4:0] w_rs1, w_rs2;
  logic       w_wr;
  logic [ALU_OP_W-1:0] w_alu_f3, w_alu_r, w_alu_i;
  logic [7:0][ALU_OP_W-1:0] w_f3_map;
  logic [XLEN-1:0] r_regs [NREGS];
  assign w_opcode = i_instruction[6:0];
  assign w_f3     = i_instruction[14:12];
  assign w_f7b5   = i_instruction[30];
  assign w_rs1    = i_instruction[19:15];
  assign w_rs2    = i_instruction[24:20];
  assign w_wr     = i_wb_en && i_wb_addr != 5'd0;
  assign w_f3_map = {AND, OR, SRL, XOR, SLTU, SLT, SLL, ADD};
  assign w_alu_f3 = w_f3_map[w_f3];
  assign w_alu_r  = (w_f7b5 && w_f3 == 3'd0) ? SUB : (w_f7b5 && w_f3 == 3'd5) ? SRA : w_alu_f3;
  // Immediate ALU ops have no SUB; f7b5 only matters for the shift-right pair.
  assign w_alu_i  = (w_f3 == 3'd0) ? ADD : (w_f7b5 && w_f3 == 3'd5) ? SRA : w_alu_f3;
  always_comb begin
    o_instr_type = T_R;
    o_alu_op     = ADD;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_use_imm    = 1'b0;
    o_is_branch  = 1'b0;
    o_is_jump    = 1'b0;
    o_is_jalr    = 1'b0;
    o_is_final   = 1'b0;
    case (w_opcode)
      7'b0110011: begin o_reg_write = 1'b1; o_alu_op = w_alu_r; end
      7'b0010011: begin o_reg_write = 1'b1; o_use_imm = 1'b1; o_instr_type = T_I; o_alu_op = w_alu_i; end
      7'b0000011: begin o_mem_read = 1'b1; o_reg_write = 1'b1; o_use_imm = 1'b1; o_instr_type = T_I; end
      7'b0100011: begin o_mem_write = 1'b1; o_use_imm = 1'b1; o_instr_type = T_S; end
      7'b1100011: begin o_is_branch = 1'b1; o_alu_op = SUB; o_instr_type = T_B; end
      7'b1101111: begin o_is_jump = 1'b1; o_reg_write = 1'b1; o_instr_type = T_J; end
      7'b1100111: begin o_is_jump = 1'b1; o_is_jalr = 1'b1; o_reg_write = 1'b1; o_use_imm = 1'b1; o_instr_type = T_I; end
      7'b0110111: begin o_reg_write = 1'b1; o_use_imm = 1'b1; o_alu_op = PASSB; o_instr_type = T_U; end
      7'b0010111: begin o_reg_write = 1'b1; o_use_imm = 1'b1; o_instr_type = T_U; end
      7'b1110011: o_is_final = 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    o_sext_imm = '0;
    case (o_instr_type)
      T_I: o_sext_imm = {{20{i_instruction[31]}}, i_instruction[31:20]};
      T_S: o_sext_imm = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
      T_B: o_sext_imm = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7], i_instruction[30:25], i_instruction[11:8], 1'b0};
      T_U: o_sext_imm = {i_instruction[31:12], 12'b0};
      T_J: o_sext_imm = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12], i_instruction[20], i_instruction[30:21], 1'b0};
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    else if (w_wr) r_regs[i_wb_addr] <= i_wb_data;
  end
  // Write-through lets a consumer see the value being written back this same cycle.
  assign o_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_wr && i_wb_addr == w_rs1) ? i_wb_data : r_regs[w_rs1];
  assign o_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_wr && i_wb_addr == w_rs2) ? i_wb_data : r_regs[w_rs2];
`ifdef DECODE_DUMP_EN
  always @(posedge clk) begin
    if (i_dump) for (int k = 0; k < NREGS; k++) $display("x%0d = 0x%08h", k, r_regs[k]);
  end
`else
  logic w_unused_dump;
  assign w_unused_dump = i_dump;
`endif
endmodule

// File: tb/tb_decode_core.sv
// tb_decode_core: randomized scoreboard bench for decode_core against a behavioural decode/register-file model.
module tb_decode_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_instruction = '0;
  logic [4:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        i_wb_en = 1'b0;
  logic        i_dump = 1'b0;
  logic [31:0] o_rs1_val, o_rs2_val, o_sext_imm;
  logic [2:0]  o_instr_type;
  logic [3:0]  o_alu_op;
  logic        o_mem_read, o_mem_write, o_reg_write, o_use_imm, o_is_branch, o_is_jump, o_is_jalr, o_is_final;
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic [7:0]  flags;
  } exp_t;
  exp_t        q[$];
  logic [31:0] m_regs [32];
  int          n_checks = 0;
  int          n_pass = 0;
  decode_core dut (
    .clk(clk), .reset(reset), .i_instruction(i_instruction), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_wb_en(i_wb_en), .i_dump(i_dump), .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_sext_imm(o_sext_imm),
    .o_instr_type(o_instr_type), .o_alu_op(o_alu_op), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_reg_write(o_reg_write), .o_use_imm(o_use_imm), .o_is_branch(o_is_branch), .o_is_jump(o_is_jump),
    .o_is_jalr(o_is_jalr), .o_is_final(o_is_final)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask
  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (i_wb_en && i_wb_addr == a) return i_wb_data;
    return m_regs[a];
  endfunction
  function automatic exp_t model(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] s;
    logic [3:0]  base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [2:0]  f3 = ins[14:12];
    logic        alt = ins[30];
    e = '0;
    e.rs1 = rd(ins[19:15]);
    e.rs2 = rd(ins[24:20]);
    case (ins[6:0])
      7'h33: begin e.flags = 8'b0010_0000; e.alu = base[f3] + ((alt && (f3 == 0 || f3 == 5)) ? 4'd1 : 4'd0); end
      7'h13: begin e.flags = 8'b0011_0000; e.typ = 1; e.alu = base[f3] + ((alt && f3 == 5) ? 4'd1 : 4'd0); end
      7'h03: begin e.flags = 8'b1011_0000; e.typ = 1; end
      7'h23: begin e.flags = 8'b0101_0000; e.typ = 2; end
      7'h63: begin e.flags = 8'b0000_1000; e.typ = 3; e.alu = 1; end
      7'h6F: begin e.flags = 8'b0010_0100; e.typ = 5; end
      7'h67: begin e.flags = 8'b0011_0110; e.typ = 1; end
      7'h37: begin e.flags = 8'b0011_0000; e.typ = 4; e.alu = 10; end
      7'h17: begin e.flags = 8'b0011_0000; e.typ = 4; end
      7'h73: e.flags = 8'b0000_0001;
      default: ;
    endcase
    case (e.typ)
      1: e.imm = $signed(ins) >>> 20;
      2: begin s = $signed(ins) >>> 25; e.imm = (s << 5) | 32'(ins[11:7]); end
      3: begin s = $signed(ins) >>> 31; e.imm = (s << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
      4: e.imm = ins & 32'hFFFF_F000;
      5: begin s = $signed(ins) >>> 31; e.imm = (s << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction
  task automatic step(input logic [31:0] ins, input logic [4:0] wa, input logic [31:0] wd, input logic we, input logic rst);
    @(posedge clk);
    if (!reset && i_wb_en && i_wb_addr != 0) m_regs[i_wb_addr] = i_wb_data;
    #1;
    reset = rst;
    if (rst) for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    i_instruction = ins;
    i_wb_addr = wa;
    i_wb_data = wd;
    i_wb_en = we;
    q.push_back(model(ins));
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs1_val", o_rs1_val, e.rs1);
        chk("rs2_val", o_rs2_val, e.rs2);
        chk("sext_imm", o_sext_imm, e.imm);
        chk("instr_type", 32'(o_instr_type), 32'(e.typ));
        chk("alu_op", 32'(o_alu_op), 32'(e.alu));
        chk("flags", 32'({o_mem_read, o_mem_write, o_reg_write, o_use_imm, o_is_branch, o_is_jump, o_is_jalr, o_is_final}), 32'(e.flags));
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : stim
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h00};
    logic [31:0] ins;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    step(32'h0052_8233, 5'd0, 32'd0, 1'b0, 1'b1);
    step(32'h0052_8233, 5'd0, 32'd0, 1'b0, 1'b0);
    step(32'h0000_0013, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(32'h0002_8033, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("x5_readback", o_rs1_val, 32'hDEAD_BEEF);
    step(32'h0000_0013, 5'd0, 32'h1234, 1'b1, 1'b0);
    step(32'h0000_0033, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("x0_write_ignored", o_rs2_val, 32'd0);
    step(32'h0003_8033, 5'd7, 32'h55, 1'b1, 1'b0);
    #1 chk("bypass_x7", o_rs1_val, 32'h55);
    step(32'h0000_0013, 5'd3, 32'h3333_3333, 1'b1, 1'b0);
    step(32'h0000_0013, 5'd4, 32'h4444_4444, 1'b1, 1'b0);
    step(32'h0041_8033, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("x3_loaded", o_rs1_val, 32'h3333_3333);
    step(32'h0041_8033, 5'd0, 32'd0, 1'b0, 1'b1);
    #1 chk("reset_x3", o_rs1_val, 32'd0);
    chk("reset_x4", o_rs2_val, 32'd0);
    step(32'h40B5_0533, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("sub_alu", 32'(o_alu_op), 32'd1);
    chk("sub_type", 32'(o_instr_type), 32'd0);
    step(32'hFFF0_0093, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("addi_imm", o_sext_imm, 32'hFFFF_FFFF);
    chk("addi_use_imm", 32'(o_use_imm), 32'd1);
    step(32'hFE00_0EE3, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("beq_imm", o_sext_imm, 32'hFFFF_FFFC);
    chk("beq_branch", 32'(o_is_branch), 32'd1);
    step(32'h1234_52B7, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("lui_imm", o_sext_imm, 32'h1234_5000);
    chk("lui_passb", 32'(o_alu_op), 32'd10);
    step(32'h0000_0073, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("ecall_flags", 32'({o_mem_read, o_mem_write, o_reg_write, o_use_imm, o_is_branch, o_is_jump, o_is_jalr, o_is_final}), 32'h01);
    step(32'h0000_007F, 5'd0, 32'd0, 1'b0, 1'b0);
    #1 chk("illegal_flags", 32'({o_mem_read, o_mem_write, o_reg_write, o_use_imm, o_is_branch, o_is_jump, o_is_jalr, o_is_final}), 32'h00);
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(10)];
      if (n % 50 == 0) ins[6:0] = 7'($urandom);
      step(ins, 5'($urandom), $urandom, 1'($urandom), (n % 150 == 149));
    end
    step(32'h0000_0013, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    if (q.size() > 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
